// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and an
// external loader/debug port. Core has priority; ext gets starvation relief and lockable bursts.
module dmem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int LOCK_MAX     = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ready,
   output logic                  cpu_stall,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [DATA_WIDTH-1:0] ext_wdata,
   input  logic                  ext_lock,
   output logic                  ext_ready,
   output logic                  ext_rvalid,
   output logic [DATA_WIDTH-1:0] ext_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  locked
);

   // state  | meaning
   // ST_ARB    | normal arbitration, core has priority unless ext is starved
   // ST_LOCKED | ext owns the memory for an atomic burst, core stalled

   typedef enum logic {ST_ARB, ST_LOCKED} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
   localparam logic [7:0] LOCK_LIM   = 8'(LOCK_MAX);

   state_t     state_q, state_d;
   logic [3:0] starve_cnt;
   logic [7:0] lock_cnt;
   logic       relock_block;
   logic       grant_cpu, grant_ext;
   logic       lock_done;

   assign lock_done = (lock_cnt == LOCK_LIM);

   always_comb begin
      grant_cpu = 1'b0;
      grant_ext = 1'b0;
      state_d   = state_q;
      case (state_q)
         ST_ARB: begin
            if (reset_n) begin
               if (cpu_req && ext_req) begin
                  if (starve_cnt >= STARVE_LIM) grant_ext = 1'b1;
                  else                          grant_cpu = 1'b1;
               end else if (cpu_req) begin
                  grant_cpu = 1'b1;
               end else if (ext_req) begin
                  grant_ext = 1'b1;
               end
            end
            // After a forced release, ext_lock must drop before a new lock is honoured.
            if (grant_ext && ext_lock && !relock_block) state_d = ST_LOCKED;
         end
         ST_LOCKED: begin
            grant_ext = ext_req & reset_n;
            if (lock_done || (grant_ext && !ext_lock) || (!ext_req && !ext_lock))
               state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_ARB;
         starve_cnt   <= '0;
         lock_cnt     <= '0;
         relock_block <= 1'b0;
         cpu_rvalid   <= 1'b0;
         ext_rvalid   <= 1'b0;
         cpu_rdata    <= '0;
         ext_rdata    <= '0;
      end else begin
         state_q <= state_d;

         if (state_d == ST_LOCKED) begin
            if (state_q == ST_ARB) lock_cnt <= 8'd1;
            else                   lock_cnt <= lock_cnt + 8'd1;
         end else begin
            lock_cnt <= '0;
         end

         if (!ext_lock)                                 relock_block <= 1'b0;
         else if (state_q == ST_LOCKED && lock_done)    relock_block <= 1'b1;

         if (grant_ext)                               starve_cnt <= '0;
         else if (ext_req && starve_cnt != 4'd15)     starve_cnt <= starve_cnt + 4'd1;

         cpu_rvalid <= grant_cpu & ~cpu_we;
         ext_rvalid <= grant_ext & ~ext_we;
         if (grant_cpu && !cpu_we) cpu_rdata <= mem_rdata;
         if (grant_ext && !ext_we) ext_rdata <= mem_rdata;
      end
   end

   assign cpu_ready = grant_cpu;
   assign ext_ready = grant_ext;
   assign cpu_stall = cpu_req & ~grant_cpu & reset_n;
   assign locked    = (state_q == ST_LOCKED);

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_cpu) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (grant_ext) begin
         mem_we    = ext_we;
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: arbitration, starvation, lock bursts,
// forced lock release and reset during a lock.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_req, cpu_we, cpu_ready, cpu_stall, cpu_rvalid;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        ext_req, ext_we, ext_lock, ext_ready, ext_rvalid;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic        mem_we, locked;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4), .LOCK_MAX(8)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_lock(ext_lock), .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .locked(locked)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h55; cpu_wdata = 32'h66;
      ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_lock = 1'b0;
      mem_rdata = 32'h0;

      // Reset: no grant possible, registered outputs cleared
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cpu_ready",  cpu_ready,  0);
      chk("rst_cpu_stall",  cpu_stall,  0);
      chk("rst_mem_we",     mem_we,     0);
      chk("rst_mem_addr",   mem_addr,   0);
      chk("rst_locked",     locked,     0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_cpu_rdata",  cpu_rdata,  0);
      chk("rst_ext_rvalid", ext_rvalid, 0);
      cpu_req = 1'b0; cpu_we = 1'b0;
      reset_n = 1'b1;
      tick();

      // Idle then single cpu read
      chk("idle_cpu_ready", cpu_ready, 0);
      chk("idle_mem_addr",  mem_addr,  0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
      #1;
      chk("rd_cpu_ready", cpu_ready, 1);
      chk("rd_mem_addr",  mem_addr,  32'h10);
      chk("rd_mem_we",    mem_we,    0);
      chk("rd_cpu_stall", cpu_stall, 0);
      tick();
      cpu_req = 1'b0; mem_rdata = 32'h0;
      #1;
      chk("rd_cpu_rvalid", cpu_rvalid, 1);
      chk("rd_cpu_rdata",  cpu_rdata,  32'hDEADBEEF);
      tick();
      chk("rd_rvalid_drop", cpu_rvalid, 0);
      chk("rd_rdata_hold",  cpu_rdata,  32'hDEADBEEF);

      // Continuous collision: ext wins every 5th cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14;
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h77;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk($sformatf("starve_ext_ready_c%0d", c), ext_ready, (c % 5) == 4);
         chk($sformatf("starve_cpu_ready_c%0d", c), cpu_ready, (c % 5) != 4);
         chk($sformatf("starve_cpu_stall_c%0d", c), cpu_stall, (c % 5) == 4);
         chk($sformatf("starve_mem_addr_c%0d", c),  mem_addr,
             ((c % 5) == 4) ? 32'h40 : 32'h14);
         tick();
      end

      // cpu write collides with ext read, starve_cnt below limit
      cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hAA;
      ext_we = 1'b0; ext_addr = 32'h30;
      #1;
      chk("col_mem_we",    mem_we,    1);
      chk("col_mem_addr",  mem_addr,  32'h20);
      chk("col_mem_wdata", mem_wdata, 32'hAA);
      chk("col_ext_ready", ext_ready, 0);
      chk("col_cpu_ready", cpu_ready, 1);
      tick();
      chk("col_starve_cnt", dut.starve_cnt, 1);
      chk("col_ext_rvalid", ext_rvalid, 0);
      cpu_req = 1'b0; mem_rdata = 32'h12345678;
      #1;
      chk("ext_rd_ready", ext_ready, 1);
      chk("ext_rd_addr",  mem_addr,  32'h30);
      tick();
      chk("ext_rd_rvalid", ext_rvalid, 1);
      chk("ext_rd_rdata",  ext_rdata,  32'h12345678);
      chk("ext_rd_starve", dut.starve_cnt, 0);

      // Locked write burst while the core keeps requesting
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
      ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1; ext_addr = 32'h100; ext_wdata = 32'h1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("lkw_wait_c%0d", c), ext_ready, 0);
         tick();
      end
      #1;
      chk("lk1_ext_ready", ext_ready, 1);
      chk("lk1_cpu_stall", cpu_stall, 1);
      chk("lk1_mem_we",    mem_we,    1);
      chk("lk1_mem_addr",  mem_addr,  32'h100);
      chk("lk1_mem_wdata", mem_wdata, 32'h1);
      tick();
      ext_addr = 32'h101; ext_wdata = 32'h2;
      #1;
      chk("lk2_locked",    locked,    1);
      chk("lk2_cpu_stall", cpu_stall, 1);
      chk("lk2_ext_ready", ext_ready, 1);
      chk("lk2_mem_addr",  mem_addr,  32'h101);
      tick();
      ext_addr = 32'h102; ext_wdata = 32'h3; ext_lock = 1'b0;
      #1;
      chk("lk3_locked",    locked,    1);
      chk("lk3_cpu_stall", cpu_stall, 1);
      chk("lk3_mem_wdata", mem_wdata, 32'h3);
      tick();
      ext_req = 1'b0;
      #1;
      chk("lk_end_locked",    locked,    0);
      chk("lk_end_cpu_ready", cpu_ready, 1);
      tick();

      // Lock held past LOCK_MAX: forced release, no relock until ext_lock toggles
      cpu_req = 1'b0;
      ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b1; ext_addr = 32'h200;
      #1;
      chk("fr_enter_ready", ext_ready, 1);
      tick();
      cpu_req = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk($sformatf("fr_locked_c%0d", c), locked, 1);
         tick();
      end
      #1;
      chk("fr_released",   locked,    0);
      chk("fr_cpu_ready",  cpu_ready, 1);
      repeat (4) tick();
      chk("fr_ext_wins",   ext_ready, 1);
      tick();
      chk("fr_no_relock",  locked,    0);
      ext_lock = 1'b0; ext_req = 1'b0; cpu_req = 1'b0;
      tick();
      ext_lock = 1'b1; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h300;
      mem_rdata = 32'hCAFE;
      #1;
      chk("rl_ext_ready", ext_ready, 1);
      tick();
      ext_addr = 32'h304; mem_rdata = 32'hBEEF;
      #1;
      chk("rl_locked",     locked,     1);
      chk("rl_ext_rvalid", ext_rvalid, 1);
      chk("rl_ext_rdata",  ext_rdata,  32'hCAFE);
      chk("rl_ext_ready2", ext_ready,  1);

      // Reset pulse during LOCKED with an ext read in flight
      reset_n = 1'b0;
      #1;
      chk("mr_locked",     locked,         0);
      chk("mr_ext_rvalid", ext_rvalid,     0);
      chk("mr_ext_rdata",  ext_rdata,      0);
      chk("mr_starve",     dut.starve_cnt, 0);
      chk("mr_ext_ready",  ext_ready,      0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      ext_req = 1'b0; ext_lock = 1'b0;
      #1;
      chk("mr_no_rvalid", ext_rvalid, 0);
      chk("mr_locked2",   locked,     0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44; ext_req = 1'b1;
      #1;
      chk("mr_cpu_ready", cpu_ready, 1);
      chk("mr_ext_wait",  ext_ready, 0);
      tick();
      chk("mr_no_rvalid2", ext_rvalid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
